tick_scheduler: RTL and testbench

Central timebase controller for the alarm clock. From the 100 MHz board clock, one shared prescaler produces a 1 kHz base tick. That tick is then scheduled into single-cycle enable pulses and a blink level for the rest of the design: display refresh, debounce sampling, seconds timekeeping and set-mode blinking. A handshaked mode interface lets the time-set logic run, hold or fast-forward the seconds tick without disturbing display or button timing.

---
 rtl/clock_pkg.sv | 25 ++
 rtl/mod_counter.sv | 47 ++++
 rtl/tick_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_tick_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg
// Shared definitions for the alarm-clock timebase:
//   - mode_e     : seconds-tick modes (RUN, HOLD, FAST) plus the reserved code
//   - DEF_*_DIV  : default divisors for a 100 MHz board clock
//   - cnt_width  : counter width for a modulo-N counter (never below 1 bit)
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_HOLD = 2'b01,
    MODE_FAST = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int DEF_BASE_DIV  = 100000;
  localparam int DEF_DEB_DIV   = 10;
  localparam int DEF_SEC_DIV   = 1000;
  localparam int DEF_FAST_DIV  = 100;
  localparam int DEF_BLINK_DIV = 250;

  function automatic int cnt_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter
// Modulo counter that advances on 'en' and returns to zero after reaching
// 'last' (the divisor minus one, supplied at runtime so a caller can switch
// divisors).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : advance by one this cycle
//   clr       : synchronous clear, wins over en, suppresses the wrap
//   last      : terminal count (divisor - 1)
//   at_last   : combinational, high in the cycle whose edge performs the wrap
//   wrap      : registered one-cycle pulse following that edge
module mod_counter
  import clock_pkg::*;
#(
  parameter int MAX_DIV = 10,
  parameter int W       = cnt_width(MAX_DIV)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic         at_last,
  output logic         wrap
);

  logic [W-1:0] count;

  // '>=' rather than '==' so a limit lowered below the current count still
  // wraps promptly instead of running round the whole counter range.
  assign at_last = en && !clr && (count >= last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= at_last;
      if (clr) begin
        count <= '0;
      end else if (en) begin
        count <= at_last ? '0 : count + W'(1);
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler
// Central timebase: a shared prescaler makes the base tick, from which the
// debounce, seconds and blink schedules are derived. The seconds schedule is
// governed by a small mode FSM (RUN / HOLD / FAST) that accepts handshaked
// requests only on base events.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   mode_req        : requested mode (00 RUN, 01 HOLD, 10 FAST, 11 reserved)
//   mode_req_valid  : request pending, held until mode_ack
//   mode_ack        : one-cycle pulse when a request is consumed
//   mode            : current mode
//   phase_clr       : restart prescaler, seconds and blink phase
//   tick_base       : base-rate pulse
//   tick_deb        : debounce-rate pulse
//   tick_sec        : seconds step pulse
//   blink           : blink level, toggles every BLINK_DIV base ticks
module tick_scheduler
  import clock_pkg::*;
#(
  parameter int BASE_DIV  = DEF_BASE_DIV,
  parameter int DEB_DIV   = DEF_DEB_DIV,
  parameter int SEC_DIV   = DEF_SEC_DIV,
  parameter int FAST_DIV  = DEF_FAST_DIV,
  parameter int BLINK_DIV = DEF_BLINK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_req,
  input  logic       mode_req_valid,
  output logic       mode_ack,
  output logic [1:0] mode,
  input  logic       phase_clr,
  output logic       tick_base,
  output logic       tick_deb,
  output logic       tick_sec,
  output logic       blink
);

  localparam int BASE_W  = cnt_width(BASE_DIV);
  localparam int DEB_W   = cnt_width(DEB_DIV);
  localparam int SEC_W   = cnt_width(SEC_DIV);
  localparam int BLINK_W = cnt_width(BLINK_DIV);

  localparam logic [BASE_W-1:0]  BASE_LAST  = BASE_W'(BASE_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_DIV - 1);
  localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(SEC_DIV - 1);
  localparam logic [SEC_W-1:0]   FAST_LAST  = SEC_W'(FAST_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic             base_event;
  logic             blink_last;
  logic             unused_deb_last;
  logic             unused_sec_last;
  logic             unused_blink_wrap;

  mode_e            mode_q;
  mode_e            mode_next;
  logic             req_pending;
  logic [1:0]       req_latched;
  logic             req_present;
  logic [1:0]       req_val;
  logic             apply;
  logic             restart_sec;
  logic             sec_en;
  logic [SEC_W-1:0] sec_last;

  // The prescaler's combinational wrap is the base event; it already
  // excludes phase_clr cycles, so every downstream schedule inherits that.
  mod_counter #(.MAX_DIV(BASE_DIV)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .clr     (phase_clr),
    .last    (BASE_LAST),
    .at_last (base_event),
    .wrap    (tick_base)
  );

  mod_counter #(.MAX_DIV(DEB_DIV)) u_deb (
    .clk     (clk),
    .rst     (rst),
    .en      (base_event),
    .clr     (1'b0),
    .last    (DEB_LAST),
    .at_last (unused_deb_last),
    .wrap    (tick_deb)
  );

  mod_counter #(.MAX_DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .en      (base_event),
    .clr     (phase_clr),
    .last    (BLINK_LAST),
    .at_last (blink_last),
    .wrap    (unused_blink_wrap)
  );

  // Seconds counter: frozen whenever the mode in force after this edge is
  // HOLD, restarted when RUN or FAST is (re)entered.
  assign sec_en   = base_event && (mode_next != MODE_HOLD);
  assign sec_last = (mode_q == MODE_FAST) ? FAST_LAST : SEC_LAST;

  mod_counter #(.MAX_DIV(SEC_DIV)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .en      (sec_en),
    .clr     (phase_clr || restart_sec),
    .last    (sec_last),
    .at_last (unused_sec_last),
    .wrap    (tick_sec)
  );

  // A request seen while mode_ack is high is the one just consumed, so it
  // is ignored for that single cycle.
  assign req_present = req_pending || (mode_req_valid && !mode_ack);
  assign req_val     = req_pending ? req_latched : mode_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode_next;
    end
  end

  always_comb begin
    mode_next   = mode_q;
    apply       = 1'b0;
    restart_sec = 1'b0;
    if (base_event && req_present) begin
      apply = 1'b1;
      case (req_val)
        MODE_RUN: begin
          mode_next   = MODE_RUN;
          restart_sec = 1'b1;
        end
        MODE_HOLD: begin
          mode_next = MODE_HOLD;
        end
        MODE_FAST: begin
          mode_next   = MODE_FAST;
          restart_sec = 1'b1;
        end
        default: begin
          mode_next = mode_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_ack    <= 1'b0;
      req_pending <= 1'b0;
      req_latched <= 2'b00;
    end else begin
      mode_ack <= apply;
      if (apply) begin
        req_pending <= 1'b0;
      end else if (mode_req_valid && !mode_ack && !req_pending) begin
        req_pending <= 1'b1;
        req_latched <= mode_req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink <= 1'b1;
    end else if (phase_clr) begin
      blink <= 1'b1;
    end else if (blink_last) begin
      blink <= ~blink;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler
// Directed bench for tick_scheduler with small divisors. A behavioural model
// derives every output from event counts since reset / phase_clr / mode
// entry; it is compared with the DUT on every falling edge, and literal
// expectations at chosen cycles pin both.
module tb_tick_scheduler;
  import clock_pkg::*;

  localparam int BASE_DIV  = 4;
  localparam int DEB_DIV   = 2;
  localparam int SEC_DIV   = 5;
  localparam int FAST_DIV  = 2;
  localparam int BLINK_DIV = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode_req = 2'b00;
  logic       mode_req_valid = 1'b0;
  logic       phase_clr = 1'b0;
  logic       mode_ack;
  logic [1:0] mode;
  logic       tick_base;
  logic       tick_deb;
  logic       tick_sec;
  logic       blink;

  int assertCount = 0;
  int failCount   = 0;
  int cyc;

  tick_scheduler #(
    .BASE_DIV  (BASE_DIV),
    .DEB_DIV   (DEB_DIV),
    .SEC_DIV   (SEC_DIV),
    .FAST_DIV  (FAST_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .mode_ack       (mode_ack),
    .mode           (mode),
    .phase_clr      (phase_clr),
    .tick_base      (tick_base),
    .tick_deb       (tick_deb),
    .tick_sec       (tick_sec),
    .blink          (blink)
  );

  always #5 clk = ~clk;

  // Cycle number: the first rising edge after reset release is cycle 1.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Behavioural model state
  int         sinceClr = 0;
  int         debN     = 0;
  int         secN     = 0;
  int         blinkN   = 0;
  logic       m_base   = 1'b0;
  logic       m_deb    = 1'b0;
  logic       m_sec    = 1'b0;
  logic       m_blink  = 1'b1;
  logic       m_ack    = 1'b0;
  logic [1:0] m_mode   = MODE_RUN;

  task automatic modelReset();
    sinceClr = 0;
    debN     = 0;
    secN     = 0;
    blinkN   = 0;
    m_base   = 1'b0;
    m_deb    = 1'b0;
    m_sec    = 1'b0;
    m_blink  = 1'b1;
    m_ack    = 1'b0;
    m_mode   = MODE_RUN;
  endtask

  task automatic modelStep();
    logic present;
    logic restart;
    logic base;
    present = mode_req_valid && !m_ack;
    restart = 1'b0;
    if (phase_clr) begin
      sinceClr = 0;
      base     = 1'b0;
      secN     = 0;
      blinkN   = 0;
      m_blink  = 1'b1;
    end else begin
      sinceClr = sinceClr + 1;
      base     = (sinceClr % BASE_DIV) == 0;
    end
    m_base = base;
    m_ack  = 1'b0;
    m_deb  = 1'b0;
    m_sec  = 1'b0;
    if (base) begin
      m_ack = present;
      if (present && mode_req != MODE_RSVD) begin
        m_mode  = mode_req;
        restart = (mode_req != MODE_HOLD);
      end
      debN  = debN + 1;
      m_deb = (debN % DEB_DIV) == 0;
      blinkN = blinkN + 1;
      if ((blinkN % BLINK_DIV) == 0) m_blink = ~m_blink;
      if (restart) begin
        secN = 0;
      end else if (m_mode != MODE_HOLD) begin
        secN  = secN + 1;
        m_sec = (secN % ((m_mode == MODE_FAST) ? FAST_DIV : SEC_DIV)) == 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelReset();
      else     modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)",
               name, actual, expected, cyc, $time);
    end
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic checkLiteral(input string name, input logic [31:0] dutVal,
                              input logic [31:0] modelVal,
                              input logic [31:0] expected);
    checkOutput(name, dutVal, expected);
    checkOutput({name, "_model"}, modelVal, expected);
  endtask

  always @(negedge clk) begin
    checkOutput("cmp_tick_base", tick_base, m_base);
    checkOutput("cmp_tick_deb",  tick_deb,  m_deb);
    checkOutput("cmp_tick_sec",  tick_sec,  m_sec);
    checkOutput("cmp_blink",     blink,     m_blink);
    checkOutput("cmp_mode",      mode,      m_mode);
    checkOutput("cmp_mode_ack",  mode_ack,  m_ack);
  end

  task automatic applyStimulus(input logic valid, input logic [1:0] req,
                               input logic clr);
    mode_req_valid = valid;
    mode_req       = req;
    phase_clr      = clr;
  endtask

  // Returns 2 time units after the rising edge of cycle n.
  task automatic gotoCycle(input int n);
    int guard;
    guard = 0;
    while (1) begin
      @(posedge clk);
      #2;
      if (cyc >= n) break;
      guard++;
      if (guard > 2000) begin
        checkOutput("goto_timeout", cyc, n);
        break;
      end
    end
  endtask

  // Moves to the falling edge of the current cycle.
  task automatic settle();
    #3;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, MODE_RUN, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int secSeen;
    int ackSeen;
    int baseSeen;

    // Reset state
    applyStimulus(1'b0, MODE_RUN, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkLiteral("rst_mode",      mode,      m_mode,  0);
    checkLiteral("rst_ack",       mode_ack,  m_ack,   0);
    checkLiteral("rst_tick_base", tick_base, m_base,  0);
    checkLiteral("rst_blink",     blink,     m_blink, 1);
    #1;
    rst = 1'b0;

    // RUN after reset release
    gotoCycle(3);  settle(); checkLiteral("run_base_c3", tick_base, m_base, 0);
    gotoCycle(4);  settle(); checkLiteral("run_base_c4", tick_base, m_base, 1);
                             checkLiteral("run_deb_c4",  tick_deb,  m_deb,  0);
    gotoCycle(8);  settle(); checkLiteral("run_deb_c8",  tick_deb,  m_deb,  1);
    gotoCycle(11); settle(); checkLiteral("run_blink_c11", blink, m_blink, 1);
    gotoCycle(12); settle(); checkLiteral("run_blink_c12", blink, m_blink, 0);
    gotoCycle(16); settle(); checkLiteral("run_sec_c16", tick_sec, m_sec, 0);
    gotoCycle(20); settle(); checkLiteral("run_sec_c20", tick_sec, m_sec, 1);
    gotoCycle(24); settle(); checkLiteral("run_blink_c24", blink, m_blink, 1);

    // HOLD requested at cycle 5
    gotoCycle(25);
    resetDut();
    gotoCycle(5);  applyStimulus(1'b1, MODE_HOLD, 1'b0);
    gotoCycle(7);  settle(); checkLiteral("hold_ack_c7", mode_ack, m_ack, 0);
    gotoCycle(8);  settle(); checkLiteral("hold_ack_c8",  mode_ack, m_ack,  1);
                             checkLiteral("hold_mode_c8", mode,     m_mode, 1);
    gotoCycle(9);  applyStimulus(1'b0, MODE_RUN, 1'b0);
    secSeen = 0;
    for (int c = 10; c <= 107; c++) begin
      gotoCycle(c);
      settle();
      if (tick_sec) secSeen++;
    end
    checkOutput("hold_tick_sec_count", secSeen, 0);
    gotoCycle(108); settle(); checkLiteral("hold_blink_c108", blink, m_blink, 0);

    // FAST from HOLD
    gotoCycle(110); applyStimulus(1'b1, MODE_FAST, 1'b0);
    gotoCycle(111); settle(); checkLiteral("fast_ack_c111", mode_ack, m_ack, 0);
    gotoCycle(112); settle(); checkLiteral("fast_ack_c112",  mode_ack, m_ack,  1);
                              checkLiteral("fast_mode_c112", mode,     m_mode, 2);
                              checkLiteral("fast_sec_c112",  tick_sec, m_sec,  0);
    gotoCycle(113); applyStimulus(1'b0, MODE_RUN, 1'b0);
    gotoCycle(116); settle(); checkLiteral("fast_sec_c116", tick_sec, m_sec, 0);
    gotoCycle(120); settle(); checkLiteral("fast_sec_c120", tick_sec, m_sec, 1);
                              checkLiteral("fast_deb_c120", tick_deb, m_deb, 1);
    gotoCycle(128); settle(); checkLiteral("fast_sec_c128", tick_sec, m_sec, 1);

    // Reserved request, held back-to-back
    gotoCycle(130); applyStimulus(1'b1, MODE_RSVD, 1'b0);
    gotoCycle(132); settle(); checkLiteral("rsvd_ack_c132",  mode_ack, m_ack,  1);
                              checkLiteral("rsvd_mode_c132", mode,     m_mode, 2);
    gotoCycle(133); settle(); checkLiteral("rsvd_ack_c133",  mode_ack, m_ack,  0);
    gotoCycle(136); settle(); checkLiteral("rsvd_ack_c136",  mode_ack, m_ack,  1);
                              checkLiteral("rsvd_mode_c136", mode,     m_mode, 2);
                              checkLiteral("rsvd_sec_c136",  tick_sec, m_sec,  1);
    gotoCycle(137); applyStimulus(1'b0, MODE_RUN, 1'b0);

    // phase_clr on a prescaler wrap with a RUN request pending
    gotoCycle(138); applyStimulus(1'b1, MODE_RUN, 1'b0);
    gotoCycle(139); applyStimulus(1'b1, MODE_RUN, 1'b1);
    gotoCycle(140); applyStimulus(1'b1, MODE_RUN, 1'b0);
    settle();
    checkLiteral("clr_base_c140",  tick_base, m_base,  0);
    checkLiteral("clr_ack_c140",   mode_ack,  m_ack,   0);
    checkLiteral("clr_blink_c140", blink,     m_blink, 1);
    checkLiteral("clr_mode_c140",  mode,      m_mode,  2);
    gotoCycle(143); settle(); checkLiteral("clr_base_c143", tick_base, m_base, 0);
    gotoCycle(144); settle(); checkLiteral("clr_base_c144", tick_base, m_base, 1);
                              checkLiteral("clr_ack_c144",  mode_ack,  m_ack,  1);
                              checkLiteral("clr_mode_c144", mode,      m_mode, 0);
                              checkLiteral("clr_sec_c144",  tick_sec,  m_sec,  0);
    gotoCycle(145); applyStimulus(1'b0, MODE_RUN, 1'b0);
    gotoCycle(151); settle(); checkLiteral("clr_blink_c151", blink, m_blink, 1);
    gotoCycle(152); settle(); checkLiteral("clr_blink_c152", blink, m_blink, 0);
    gotoCycle(160); settle(); checkLiteral("clr_sec_c160", tick_sec, m_sec, 0);
    gotoCycle(164); settle(); checkLiteral("clr_sec_c164", tick_sec, m_sec, 1);

    // Reset while a FAST request is pending (mode is HOLD at that point)
    gotoCycle(170); applyStimulus(1'b1, MODE_HOLD, 1'b0);
    gotoCycle(172); settle(); checkLiteral("pre_rst_mode_c172", mode, m_mode, 1);
    gotoCycle(173); applyStimulus(1'b0, MODE_RUN, 1'b0);
    gotoCycle(174); applyStimulus(1'b1, MODE_FAST, 1'b0);
    gotoCycle(175);
    rst = 1'b1;
    applyStimulus(1'b0, MODE_RUN, 1'b0);
    #1;
    checkLiteral("arst_mode",      mode,      m_mode,  0);
    checkLiteral("arst_ack",       mode_ack,  m_ack,   0);
    checkLiteral("arst_tick_base", tick_base, m_base,  0);
    checkLiteral("arst_tick_deb",  tick_deb,  m_deb,   0);
    checkLiteral("arst_tick_sec",  tick_sec,  m_sec,   0);
    checkLiteral("arst_blink",     blink,     m_blink, 1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Timing restarts exactly as after the first reset
    ackSeen  = 0;
    baseSeen = 0;
    secSeen  = 0;
    for (int c = 1; c <= 24; c++) begin
      gotoCycle(c);
      settle();
      if (mode_ack)  ackSeen++;
      if (tick_base) baseSeen++;
      if (tick_sec)  secSeen++;
      if (c == 4)  checkLiteral("rerun_base_c4",   tick_base, m_base,  1);
      if (c == 12) checkLiteral("rerun_blink_c12", blink,     m_blink, 0);
      if (c == 20) checkLiteral("rerun_sec_c20",   tick_sec,  m_sec,   1);
    end
    checkOutput("rerun_ack_count",  ackSeen,  0);
    checkOutput("rerun_base_count", baseSeen, 6);
    checkOutput("rerun_sec_count",  secSeen,  1);
    checkLiteral("rerun_mode_c24", mode, m_mode, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
